// File: rtl/sprite_pkg.sv
// Shared constants, descriptor field positions and FSM encoding for the sprite line fetcher.
package sprite_pkg;

  localparam int SIZE_X       = 10;
  localparam int SIZE_Y       = 9;
  localparam int SIZE_ADDRESS = 17;
  localparam int SPRITE_DIM   = 20;
  localparam int NUM_SPRITES  = 288;
  localparam int ADDRESS_BG   = 115200;

  localparam int IDX_HI = 26;
  localparam int IDX_LO = 18;
  localparam int X_HI   = 17;
  localparam int X_LO   = 9;
  localparam int Y_HI   = 8;
  localparam int Y_LO   = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    FETCH = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/sprite_line_fetch_if.sv
// Request/descriptor side and memory-read side of the sprite line fetcher.
interface sprite_line_fetch_if;
  import sprite_pkg::*;

  logic                    sprite_on;
  logic [31:0]             sprite_datas;
  logic [SIZE_X-1:0]       pixel_x;
  logic [SIZE_Y-1:0]       pixel_y;
  logic [SIZE_ADDRESS-1:0] memory_address;
  logic                    addr_valid;
  logic                    count_finished;
  logic                    fetch_error;

  modport master (
    output sprite_on, sprite_datas, pixel_x, pixel_y,
    input  memory_address, addr_valid, count_finished, fetch_error
  );

  modport slave (
    input  sprite_on, sprite_datas, pixel_x, pixel_y,
    output memory_address, addr_valid, count_finished, fetch_error
  );

endinterface

// File: rtl/sprite_addr_calc.sv
// Combinational sprite-memory base address: index*400 + row*20 + col, shift-add only.
module sprite_addr_calc
  import sprite_pkg::*;
(
  input  logic [8:0]              index,
  input  logic [8:0]              row,
  input  logic [8:0]              col,
  output logic [SIZE_ADDRESS-1:0] base
);

  logic [SIZE_ADDRESS-1:0] idx_w;
  logic [SIZE_ADDRESS-1:0] row_w;
  logic [SIZE_ADDRESS-1:0] col_w;

  always_comb begin
    idx_w = SIZE_ADDRESS'(index);
    row_w = SIZE_ADDRESS'(row);
    col_w = SIZE_ADDRESS'(col);
    // 400 = 256+128+16, 20 = 16+4
    base  = (idx_w << 8) + (idx_w << 7) + (idx_w << 4)
          + (row_w << 4) + (row_w << 2) + col_w;
  end

endmodule

// File: rtl/sprite_line_fetch.sv
// Turns a sprite descriptor into a back-to-back burst of sprite-memory addresses for one screen line,
// falling back to the background word on a miss, then holds count_finished until the request drops.
module sprite_line_fetch
  import sprite_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  sprite_line_fetch_if.slave bus
);

  state_t                  state, state_nxt;
  logic [8:0]              idx_q, row_q, col_q;
  logic [SIZE_ADDRESS-1:0] cur_addr;
  logic [4:0]              rem_q;
  logic [SIZE_ADDRESS-1:0] base;
  logic                    miss;

  logic [SIZE_ADDRESS-1:0] addr_q, addr_nxt;
  logic                    vld_q, vld_nxt;
  logic                    fin_q, fin_nxt;
  logic                    err_q, err_nxt;

  logic unused_bits;
  assign unused_bits = ^{bus.sprite_datas[31:IDX_HI+1], bus.pixel_x[SIZE_X-1:9]};

  sprite_addr_calc u_addr_calc (
    .index (idx_q),
    .row   (row_q),
    .col   (col_q),
    .base  (base)
  );

  // Unsigned compares: a negative row/col wraps high and counts as a miss.
  assign miss = (idx_q >= 9'(NUM_SPRITES)) || (row_q >= 9'(SPRITE_DIM)) || (col_q >= 9'(SPRITE_DIM));

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.sprite_on) state_nxt = CALC;
      CALC:    state_nxt = miss ? DONE : FETCH;
      FETCH: begin
        if (!bus.sprite_on)    state_nxt = IDLE;
        else if (rem_q == 5'd1) state_nxt = DONE;
      end
      DONE:    if (!bus.sprite_on) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    addr_nxt = addr_q;
    vld_nxt  = 1'b0;
    fin_nxt  = 1'b0;
    err_nxt  = 1'b0;
    case (state)
      CALC: if (miss) begin
        addr_nxt = SIZE_ADDRESS'(ADDRESS_BG);
        vld_nxt  = 1'b1;
        err_nxt  = 1'b1;
      end
      FETCH: if (bus.sprite_on) begin
        addr_nxt = cur_addr;
        vld_nxt  = 1'b1;
      end
      DONE:    fin_nxt = bus.sprite_on;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      cur_addr <= '0;
      rem_q    <= '0;
      addr_q   <= '0;
      vld_q    <= 1'b0;
      fin_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      addr_q <= addr_nxt;
      vld_q  <= vld_nxt;
      fin_q  <= fin_nxt;
      err_q  <= err_nxt;
      case (state)
        IDLE: if (bus.sprite_on) begin
          idx_q <= bus.sprite_datas[IDX_HI:IDX_LO];
          row_q <= bus.pixel_y - bus.sprite_datas[Y_HI:Y_LO];
          col_q <= bus.pixel_x[8:0] - bus.sprite_datas[X_HI:X_LO];
        end
        CALC: begin
          cur_addr <= base;
          rem_q    <= 5'(SPRITE_DIM) - col_q[4:0];
        end
        FETCH: if (bus.sprite_on) begin
          cur_addr <= cur_addr + 1'b1;
          rem_q    <= rem_q - 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.memory_address = addr_q;
  assign bus.addr_valid     = vld_q;
  assign bus.count_finished = fin_q;
  assign bus.fetch_error    = err_q;

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Directed bench for sprite_line_fetch: full/partial rows, misses, abort and mid-burst reset.
module tb_sprite_line_fetch;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  sprite_line_fetch_if bus ();

  sprite_line_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input int ox, input int oy, input int px, input int py);
    logic [8:0] i9, x9, y9;
    i9 = 9'(idx);
    x9 = 9'(ox);
    y9 = 9'(oy);
    bus.sprite_datas = {5'b10101, i9, x9, y9};
    bus.pixel_x      = 10'(px);
    bus.pixel_y      = 9'(py);
    bus.sprite_on    = 1'b1;
  endtask

  // Full request/response: n addresses from base, or one background fetch when err is set.
  task automatic run_req(input string tag, input int idx, input int ox, input int oy,
                         input int px, input int py, input int base, input int n, input bit err);
    int last;
    set_req(idx, ox, oy, px, py);
    tick();
    check({tag, " calc_vld"}, 32'(bus.addr_valid), 0);
    tick();
    if (err) begin
      check({tag, " bg_vld"}, 32'(bus.addr_valid), 1);
      check({tag, " bg_addr"}, 32'(bus.memory_address), 115200);
      check({tag, " err_pulse"}, 32'(bus.fetch_error), 1);
      last = 115200;
    end else begin
      check({tag, " pre_vld"}, 32'(bus.addr_valid), 0);
      for (int k = 0; k < n; k++) begin
        tick();
        check({tag, " vld"}, 32'(bus.addr_valid), 1);
        check({tag, " addr"}, 32'(bus.memory_address), base + k);
        check({tag, " no_err"}, 32'(bus.fetch_error), 0);
        check({tag, " no_fin"}, 32'(bus.count_finished), 0);
      end
      last = base + n - 1;
    end
    tick();
    check({tag, " fin"}, 32'(bus.count_finished), 1);
    check({tag, " fin_vld"}, 32'(bus.addr_valid), 0);
    check({tag, " err_clr"}, 32'(bus.fetch_error), 0);
    tick();
    check({tag, " fin_hold"}, 32'(bus.count_finished), 1);
    bus.sprite_on = 1'b0;
    tick();
    check({tag, " fin_drop"}, 32'(bus.count_finished), 0);
    check({tag, " addr_hold"}, 32'(bus.memory_address), last);
  endtask

  initial begin
    reset            = 1'b0;
    bus.sprite_on    = 1'b0;
    bus.sprite_datas = '0;
    bus.pixel_x      = '0;
    bus.pixel_y      = '0;
    tick();
    tick();
    check("rst addr", 32'(bus.memory_address), 0);
    check("rst vld", 32'(bus.addr_valid), 0);
    check("rst fin", 32'(bus.count_finished), 0);
    check("rst err", 32'(bus.fetch_error), 0);
    reset = 1'b1;
    tick();

    run_req("full",    2,   100, 50, 100, 53, 860, 20, 1'b0);
    run_req("partial", 2,   100, 50, 115, 53, 875, 5,  1'b0);
    run_req("lastcol", 2,   100, 50, 119, 53, 879, 1,  1'b0);
    run_req("top_spr", 287, 0,   0,  0,   19, 115180, 20, 1'b0);
    run_req("badidx",  288, 100, 50, 100, 53, 0,   0,  1'b1);
    run_req("rowmiss", 2,   100, 50, 100, 49, 0,   0,  1'b1);
    run_req("colmiss", 2,   100, 50, 120, 53, 0,   0,  1'b1);

    // Abort after 7 addresses of a full row.
    set_req(2, 100, 50, 100, 53);
    tick();
    tick();
    for (int k = 0; k < 7; k++) begin
      tick();
      check("abort addr", 32'(bus.memory_address), 860 + k);
    end
    bus.sprite_on = 1'b0;
    tick();
    check("abort vld", 32'(bus.addr_valid), 0);
    check("abort fin", 32'(bus.count_finished), 0);
    tick();
    check("abort fin2", 32'(bus.count_finished), 0);
    check("abort vld2", 32'(bus.addr_valid), 0);
    run_req("after_abort", 2, 100, 50, 115, 53, 875, 5, 1'b0);

    // Reset asserted on the 4th address cycle.
    set_req(2, 100, 50, 100, 53);
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rstmid addr", 32'(bus.memory_address), 860 + k);
    end
    reset = 1'b0;
    tick();
    check("rstmid vld", 32'(bus.addr_valid), 0);
    check("rstmid fin", 32'(bus.count_finished), 0);
    check("rstmid addr0", 32'(bus.memory_address), 0);
    reset         = 1'b1;
    bus.sprite_on = 1'b0;
    tick();
    check("rstmid idle_vld", 32'(bus.addr_valid), 0);
    run_req("after_rst", 2, 100, 50, 100, 53, 860, 20, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
